// File: rtl/sum_log_pkg.sv
// Shared defaults for the sum_log capture/log slice: widths, FIFO depth and the sum type.
package sum_log_pkg;

  localparam int SUM_DATA_W = 8;
  localparam int SUM_DEPTH  = 4;
  localparam int SUM_TOT_W  = 16;

  typedef logic [SUM_DATA_W-1:0] sum_t;

endpackage

// File: rtl/sum_log_fifo.sv
// First-word fall-through FIFO for captured sums; push/pop/clr arrive already qualified.
module sum_log_fifo
  import sum_log_pkg::*;
#(
  parameter  int DATA_W = SUM_DATA_W,
  parameter  int DEPTH  = SUM_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              ck,
  input  logic              reset_l,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Storage carries no reset; stale slots are unreachable once the pointers clear.
  always_ff @(posedge ck) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge ck) begin
    if (!reset_l || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sum_log.sv
// Captures accumulator sums into a FIFO, tracks a wrapping grand total and a sticky drop flag.
// Define SUM_LOG_MAX_EN to build the running maximum register behind max_sum.
module sum_log
  import sum_log_pkg::*;
#(
  parameter  int DATA_W = SUM_DATA_W,
  parameter  int DEPTH  = SUM_DEPTH,
  parameter  int TOT_W  = SUM_TOT_W,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              ck,
  input  logic              reset_l,
  input  logic              done,
  input  logic [DATA_W-1:0] sum,
  input  logic              clr_l,
  input  logic              rd_l,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic [TOT_W-1:0]  total,
  output logic [DATA_W-1:0] max_sum
);

  logic push;
  logic pop;
  logic drop;
  logic clr;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign clr  = ~clr_l;
  assign pop  = ~rd_l & ~empty;
  assign push = done & (~full | pop);
  assign drop = done & full & ~pop;

  sum_log_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .ck      (ck),
    .reset_l (reset_l),
    .clr     (clr),
    .push    (push),
    .pop     (pop),
    .wr_data (sum),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  always_ff @(posedge ck) begin
    if (!reset_l || clr) begin
      ovf   <= 1'b0;
      total <= '0;
    end else begin
      if (drop) ovf <= 1'b1;
      if (push) total <= total + TOT_W'(sum);
    end
  end

`ifdef SUM_LOG_MAX_EN
  always_ff @(posedge ck) begin
    if (!reset_l || clr) begin
      max_sum <= '0;
    end else if (push && (sum > max_sum)) begin
      max_sum <= sum;
    end
  end
`else
  assign max_sum = '0;
`endif

endmodule

// File: tb/tb_sum_log.sv
// Bench for sum_log: directed scenarios plus random traffic against a queue-based reference model.
module tb_sum_log;
  import sum_log_pkg::*;

  localparam int DATA_W = SUM_DATA_W;
  localparam int DEPTH  = SUM_DEPTH;
  localparam int TOT_W  = SUM_TOT_W;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
`ifdef SUM_LOG_MAX_EN
  localparam bit MAX_EN = 1'b1;
`else
  localparam bit MAX_EN = 1'b0;
`endif

  logic              ck = 1'b0;
  logic              reset_l;
  logic              done;
  sum_t              sum;
  logic              clr_l;
  logic              rd_l;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic [TOT_W-1:0]  total;
  logic [DATA_W-1:0] max_sum;

  int q[$];
  int m_total;
  bit m_ovf;
  int m_max;
  int n_checks;
  int n_err;

  sum_log dut (
    .ck      (ck),
    .reset_l (reset_l),
    .done    (done),
    .sum     (sum),
    .clr_l   (clr_l),
    .rd_l    (rd_l),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .ovf     (ovf),
    .total   (total),
    .max_sum (max_sum)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: a bounded queue with drop-on-full, wrapped total and running max.
  task automatic model_edge();
    bit popping;
    bit was_full;
    if (!reset_l || !clr_l) begin
      q.delete();
      m_total = 0;
      m_ovf   = 1'b0;
      m_max   = 0;
    end else begin
      popping  = !rd_l && (q.size() > 0);
      was_full = (q.size() == DEPTH);
      if (popping) void'(q.pop_front());
      if (done) begin
        if (was_full && !popping) begin
          m_ovf = 1'b1;
        end else begin
          q.push_back(int'(sum));
          m_total = (m_total + int'(sum)) % (1 << TOT_W);
          if (int'(sum) > m_max) m_max = int'(sum);
        end
      end
    end
  endtask

  task automatic chk_all();
    chk("rd_data", 32'(rd_data), (q.size() > 0) ? q[0] : 0);
    chk("count",   32'(count),   q.size());
    chk("empty",   32'(empty),   32'(q.size() == 0));
    chk("full",    32'(full),    32'(q.size() == DEPTH));
    chk("ovf",     32'(ovf),     32'(m_ovf));
    chk("total",   32'(total),   m_total);
    chk("max_sum", 32'(max_sum), MAX_EN ? m_max : 0);
  endtask

  task automatic step();
    @(posedge ck);
    model_edge();
    #1;
    chk_all();
  endtask

  task automatic drive(input logic d, input int s, input logic r);
    done = d;
    sum  = sum_t'(s);
    rd_l = r;
  endtask

  task automatic clear_once();
    drive(1'b0, 0, 1'b1);
    clr_l = 1'b0;
    step();
    clr_l = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    m_total  = 0;
    m_ovf    = 1'b0;
    m_max    = 0;
    reset_l  = 1'b0;
    clr_l    = 1'b1;
    drive(1'b0, 0, 1'b1);

    // Reset and idle
    step();
    step();
    reset_l = 1'b1;
    step();
    chk("t1_empty", 32'(empty), 1);
    chk("t1_count", 32'(count), 0);
    chk("t1_ovf", 32'(ovf), 0);
    chk("t1_total", 32'(total), 0);
    chk("t1_rd_data", 32'(rd_data), 0);

    // Back-to-back captures, then drain
    drive(1'b1, 5, 1'b1); step();
    drive(1'b1, 9, 1'b1); step();
    drive(1'b1, 3, 1'b1); step();
    chk("t2_count", 32'(count), 3);
    chk("t2_head", 32'(rd_data), 5);
    chk("t2_total", 32'(total), 17);
    chk("t2_max", 32'(max_sum), MAX_EN ? 9 : 0);
    drive(1'b0, 0, 1'b0); step();
    chk("t2_pop1", 32'(rd_data), 9);
    step();
    chk("t2_pop2", 32'(rd_data), 3);
    step();
    chk("t2_empty", 32'(empty), 1);
    step();
    chk("t2_pop_empty_count", 32'(count), 0);

    // Overflow drop
    clear_once();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 10 * i, 1'b1); step();
    end
    drive(1'b1, 50, 1'b1); step();
    chk("t3_full", 32'(full), 1);
    chk("t3_ovf", 32'(ovf), 1);
    chk("t3_total", 32'(total), 100);
    drive(1'b0, 0, 1'b0); step();
    chk("t3_head", 32'(rd_data), 20);
    chk("t3_ovf_sticky", 32'(ovf), 1);

    // Push and pop together while full
    clear_once();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 10 * i, 1'b1); step();
    end
    drive(1'b1, 7, 1'b0); step();
    chk("t4_count", 32'(count), 4);
    chk("t4_ovf", 32'(ovf), 0);
    chk("t4_total", 32'(total), 107);
    chk("t4_head0", 32'(rd_data), 20);
    drive(1'b0, 0, 1'b0); step();
    chk("t4_head1", 32'(rd_data), 30);
    step();
    chk("t4_head2", 32'(rd_data), 40);
    step();
    chk("t4_head3", 32'(rd_data), 7);
    step();
    chk("t4_drained", 32'(empty), 1);

    // Clear beats a concurrent capture
    clear_once();
    drive(1'b1, 8'h7F, 1'b1); step();
    drive(1'b1, 8'h80, 1'b1); step();
    chk("t5_count", 32'(count), 2);
    chk("t5_total", 32'(total), 32'h00FF);
    drive(1'b1, 8'h55, 1'b1);
    clr_l = 1'b0;
    step();
    clr_l = 1'b1;
    chk("t5_cnt_clr", 32'(count), 0);
    chk("t5_tot_clr", 32'(total), 0);
    chk("t5_empty_clr", 32'(empty), 1);

    // Total wrap, then reset mid-burst
    clear_once();
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 8'hFF, 1'b0); step();
    end
    drive(1'b1, 8'hF0, 1'b0); step();
    chk("t6_total_pre", 32'(total), 32'hFFF0);
    drive(1'b1, 8'h20, 1'b0); step();
    chk("t6_total_wrap", 32'(total), 32'h0010);
    chk("t6_no_ovf", 32'(ovf), 0);
    drive(1'b1, 8'h33, 1'b1);
    reset_l = 1'b0;
    step();
    reset_l = 1'b1;
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_total", 32'(total), 0);
    chk("t6_rst_rd", 32'(rd_data), 0);
    chk("t6_rst_max", 32'(max_sum), 0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      clr_l   = ($urandom_range(0, 39) != 0);
      reset_l = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
